// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline types and constants for hazard control
// Contents: md_state_e (HI/LO unit FSM encoding), REG_ZERO, reg_hit() helper.
package hazard_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A producer only matters if it targets a real register; $0 is hardwired.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-unit signal bundle
// master: pipeline side, drives decode/EX/MEM status, receives stall/flush/forward.
// slave:  hazard unit side, the reverse directions.
interface hazard_ctrl_if;
    logic [4:0] Rs_D, Rt_D;
    logic [4:0] writeRegE, writeRegM;
    logic       regWriteE, regWriteM;
    logic       memToRegE, memToRegM;
    logic       branchD, pcSrcD, jumpD;
    logic       mdStartE, mdUseD;
    logic       forwardAD, forwardBD;
    logic       stallF, stallD;
    logic       flushE, flushD;
    logic       mdBusy, mdDone;

    modport master (
        output Rs_D, Rt_D, writeRegE, writeRegM, regWriteE, regWriteM,
               memToRegE, memToRegM, branchD, pcSrcD, jumpD, mdStartE, mdUseD,
        input  forwardAD, forwardBD, stallF, stallD, flushE, flushD, mdBusy, mdDone
    );

    modport slave (
        input  Rs_D, Rt_D, writeRegE, writeRegM, regWriteE, regWriteM,
               memToRegE, memToRegM, branchD, pcSrcD, jumpD, mdStartE, mdUseD,
        output forwardAD, forwardBD, stallF, stallD, flushE, flushD, mdBusy, mdDone
    );
endinterface

// File: rtl/hazard_ctrl_md_tracker.sv
// rtl/hazard_ctrl_md_tracker.sv - HI/LO multiply/divide occupancy tracker
// Ports: clk, reset (sync, active-high), md_start_i (op enters EX),
//        md_busy_o (unit occupied, MD_LATENCY cycles), md_done_o (1-cycle result pulse).
module md_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_i,
    output logic md_busy_o,
    output logic md_done_o
);

    localparam logic [5:0] CNT_LOAD = 6'(MD_LATENCY - 1);

    md_state_e  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Starts are only accepted in IDLE, so a start seen on the final BUSY
    // cycle (or any BUSY cycle) is dropped rather than chained.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q == 6'd0) begin
                    state_d = MD_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign md_busy_o = (state_q == MD_BUSY);
    assign md_done_o = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard detection, branch forwarding, HI/LO interlock
// Ports: clk, reset (sync, active-high), hz (hazard_ctrl_if.slave): decode/EX/MEM
//        status in; forwardAD/BD, stallF/D, flushE/D, mdBusy, mdDone out.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    logic lw_stall;
    logic br_stall;
    logic md_stall;
    logic stall;
    logic md_busy;
    logic md_done;

    md_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_tracker (
        .clk        (clk),
        .reset      (reset),
        .md_start_i (hz.mdStartE),
        .md_busy_o  (md_busy),
        .md_done_o  (md_done)
    );

    // Decode-stage comparator can take the MEM ALU result directly.
    assign hz.forwardAD = hz.regWriteM && reg_hit(hz.Rs_D, hz.writeRegM);
    assign hz.forwardBD = hz.regWriteM && reg_hit(hz.Rt_D, hz.writeRegM);

    // Load in EX: its data is not available until after MEM.
    assign lw_stall = hz.memToRegE && hz.regWriteE &&
                      (reg_hit(hz.Rs_D, hz.writeRegE) || reg_hit(hz.Rt_D, hz.writeRegE));

    // Branch compares in decode: any EX producer is too late, and a load in
    // MEM has no forwardable ALU result yet.
    assign br_stall = hz.branchD &&
                      ((hz.regWriteE &&
                        (reg_hit(hz.Rs_D, hz.writeRegE) || reg_hit(hz.Rt_D, hz.writeRegE))) ||
                       (hz.memToRegM &&
                        (reg_hit(hz.Rs_D, hz.writeRegM) || reg_hit(hz.Rt_D, hz.writeRegM))));

    // Gated by reset so a BUSY state about to be cleared cannot stall.
    assign md_stall = hz.mdUseD && md_busy && !reset;

    assign stall     = lw_stall || br_stall || md_stall;
    assign hz.stallF = stall;
    assign hz.stallD = stall;
    assign hz.flushE = stall;
    assign hz.flushD = (hz.pcSrcD || hz.jumpD) && !stall;

    assign hz.mdBusy = md_busy;
    assign hz.mdDone = md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed table-driven bench for hazard_ctrl (MD_LATENCY=4)
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MD_LATENCY (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, we, wm;
        logic       rwe, rwm, mte, mtm, br, pc, jp;
        logic       e_fad, e_fbd, e_stall, e_flushd;
    } vec_t;

    localparam int NV = 13;
    vec_t tv [NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.Rs_D = 5'd0; hz.Rt_D = 5'd0; hz.writeRegE = 5'd0; hz.writeRegM = 5'd0;
        hz.regWriteE = 1'b0; hz.regWriteM = 1'b0; hz.memToRegE = 1'b0; hz.memToRegM = 1'b0;
        hz.branchD = 1'b0; hz.pcSrcD = 1'b0; hz.jumpD = 1'b0;
        hz.mdStartE = 1'b0; hz.mdUseD = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // {mdBusy, mdDone, stallD}
    function automatic logic [7:0] md_obs();
        return {5'd0, hz.mdBusy, hz.mdDone, hz.stallD};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();

        //            rs    rt    we    wm   rwe  rwm  mte  mtm  br   pc   jp   fad  fbd  stl  fld
        tv[0]  = '{5'd8, 5'd0, 5'd8, 5'd0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0}; // load-use
        tv[1]  = '{5'd0, 5'd9, 5'd0, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0}; // branch fwd B
        tv[2]  = '{5'd0, 5'd9, 5'd0, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1}; // taken -> flushD
        tv[3]  = '{5'd5, 5'd0, 5'd0, 5'd5, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0}; // branch on MEM load
        tv[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // reg zero
        tv[5]  = '{5'd0, 5'd3, 5'd3, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0}; // branch on EX ALU
        tv[6]  = '{5'd0, 5'd3, 5'd3, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // non-branch ALU dep
        tv[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1}; // jump
        tv[8]  = '{5'd0, 5'd7, 5'd7, 5'd0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0}; // stalled jump
        tv[9]  = '{5'd4, 5'd0, 5'd4, 5'd0, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0}; // lw + br
        tv[10] = '{5'd8, 5'd0, 5'd8, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // no regWriteE
        tv[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // zero in MEM
        tv[12] = '{5'd6, 5'd6, 5'd0, 5'd6, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0}; // fwd A and B

        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        check("reset_md_state", md_obs(), 8'b000);
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            clear_inputs();
            hz.Rs_D = tv[i].rs; hz.Rt_D = tv[i].rt;
            hz.writeRegE = tv[i].we; hz.writeRegM = tv[i].wm;
            hz.regWriteE = tv[i].rwe; hz.regWriteM = tv[i].rwm;
            hz.memToRegE = tv[i].mte; hz.memToRegM = tv[i].mtm;
            hz.branchD = tv[i].br; hz.pcSrcD = tv[i].pc; hz.jumpD = tv[i].jp;
            #1;
            check($sformatf("vec%0d", i),
                  {2'b00, hz.forwardAD, hz.forwardBD, hz.stallF, hz.stallD, hz.flushE, hz.flushD},
                  {2'b00, tv[i].e_fad, tv[i].e_fbd, tv[i].e_stall, tv[i].e_stall, tv[i].e_stall,
                   tv[i].e_flushd});
            next_cycle();
        end

        // Multiply: start in cycle 0; spurious starts while BUSY and on the
        // final BUSY cycle must be ignored.
        clear_inputs();
        hz.mdStartE = 1'b1;
        check("md_idle_no_stall", md_obs(), 8'b000);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            hz.mdUseD   = 1'b1;
            hz.mdStartE = (c == 2 || c == 4);
            #1;
            if (c <= 4)
                check($sformatf("md_cycle%0d", c), md_obs(), 8'b101);
            else if (c == 5)
                check("md_cycle5_done", md_obs(), 8'b010);
            else
                check("md_cycle6_idle", md_obs(), 8'b000);
        end

        // Reset during cycle 2 of an op abandons it without a done pulse.
        clear_inputs();
        next_cycle();
        hz.mdStartE = 1'b1;
        next_cycle();
        hz.mdStartE = 1'b0;
        hz.mdUseD   = 1'b1;
        next_cycle();
        reset = 1'b1;
        #1;
        check("rst_cycle2_no_stall", {7'd0, hz.stallD}, 8'd0);
        next_cycle();
        reset = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            #1;
            check($sformatf("rst_after_c%0d", c), md_obs(), 8'b000);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
